alu: RTL and testbench



---
 rtl/alu.sv | 76 +++++++
 tb/tb_alu.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// rtl/alu.sv - single-cycle 16-bit ALU (add, sub, and, not-B) with registered result and Z/N/V flags
module alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] Ain,
    input  logic [15:0] Bin,
    input  logic [1:0]  ALUop,
    input  logic        load,
    output logic [15:0] out,
    output logic        Z,
    output logic        N,
    output logic        V,
    output logic        valid
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    logic        is_sub;
    logic [15:0] b_eff;
    logic [15:0] sum;
    logic        sum_ovf;
    logic [15:0] r_d;
    logic        v_d;

    logic [15:0] out_q;
    logic        z_q;
    logic        n_q;
    logic        v_q;
    logic        valid_q;

    // Subtraction reuses the adder as Ain + ~Bin + 1, so one overflow rule covers both.
    assign is_sub  = (ALUop == OP_SUB);
    assign b_eff   = is_sub ? ~Bin : Bin;
    assign sum     = Ain + b_eff + {15'b0, is_sub};
    assign sum_ovf = (Ain[15] == b_eff[15]) && (sum[15] != Ain[15]);

    always_comb begin
        r_d = ~Bin;
        v_d = 1'b0;
        case (ALUop)
            OP_ADD, OP_SUB: begin
                r_d = sum;
                v_d = sum_ovf;
            end
            OP_AND:  r_d = Ain & Bin;
            default: r_d = ~Bin;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= 16'h0000;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= load;
            if (load) begin
                out_q <= r_d;
                z_q   <= (r_d == 16'h0000);
                n_q   <= r_d[15];
                v_q   <= v_d;
            end
        end
    end

    assign out   = out_q;
    assign Z     = z_q;
    assign N     = n_q;
    assign V     = v_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - randomized and directed self-checking bench for alu against an arithmetic reference model
module tb_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] Ain = 16'h0;
    logic [15:0] Bin = 16'h0;
    logic [1:0]  ALUop = 2'b00;
    logic        load = 1'b0;
    logic [15:0] out;
    logic        Z;
    logic        N;
    logic        V;
    logic        valid;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_out = 16'h0;
    logic        m_z = 1'b0;
    logic        m_n = 1'b0;
    logic        m_v = 1'b0;
    logic        m_valid = 1'b0;

    alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Ain   (Ain),
        .Bin   (Bin),
        .ALUop (ALUop),
        .load  (load),
        .out   (out),
        .Z     (Z),
        .N     (N),
        .V     (V),
        .valid (valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: signed overflow decided by whether the true integer result fits in 16 bits.
    task automatic model_calc(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                              output logic [15:0] r, output logic v);
        int sa;
        int sb;
        int s;
        sa = int'($signed(a));
        sb = int'($signed(b));
        v = 1'b0;
        case (op)
            2'd0: begin
                s = sa + sb;
                r = 16'(s);
                v = (s > 32767) || (s < -32768);
            end
            2'd1: begin
                s = sa - sb;
                r = 16'(s);
                v = (s > 32767) || (s < -32768);
            end
            2'd2: r = a & b;
            default: r = ~b;
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        logic [15:0] r;
        logic        v;
        if (!rst_n) begin
            m_out = 16'h0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0; m_valid = 1'b0;
        end else begin
            m_valid = load;
            if (load) begin
                model_calc(Ain, Bin, ALUop, r, v);
                m_out = r;
                m_z   = (r == 16'h0);
                m_n   = r[15];
                m_v   = v;
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_out",   out,          m_out);
        chk("cmp_z",     16'(Z),       16'(m_z));
        chk("cmp_n",     16'(N),       16'(m_n));
        chk("cmp_v",     16'(V),       16'(m_v));
        chk("cmp_valid", 16'(valid),   16'(m_valid));
    end

    task automatic op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o);
        Ain = a; Bin = b; ALUop = o; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic expect_all(input string name, input logic [15:0] eo, input logic ez,
                              input logic en, input logic ev, input logic evalid);
        chk({name, "_out"},   out,        eo);
        chk({name, "_z"},     16'(Z),     16'(ez));
        chk({name, "_n"},     16'(N),     16'(en));
        chk({name, "_v"},     16'(V),     16'(ev));
        chk({name, "_valid"}, 16'(valid), 16'(evalid));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        expect_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        op(16'd5, 16'd7, 2'b00);
        expect_all("add5_7", 16'd12, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("add_valid_one_cycle", 16'(valid), 16'h0);

        op(16'd10, 16'd3, 2'b01);
        expect_all("sub10_3", 16'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        op(16'd45, 16'd45, 2'b01);
        expect_all("sub45_45", 16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        op(16'd15, 16'd60, 2'b10);
        expect_all("and15_60", 16'd12, 1'b0, 1'b0, 1'b0, 1'b1);
        op(16'hA5A5, 16'h00FF, 2'b11);
        expect_all("not_ff", 16'hFF00, 1'b0, 1'b1, 1'b0, 1'b1);
        op(16'h7FFF, 16'h0001, 2'b00);
        expect_all("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b1, 1'b1);
        op(16'h8000, 16'h0001, 2'b01);
        expect_all("sub_ovf", 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b1);
        op(16'hFFFF, 16'h0001, 2'b00);
        expect_all("add_wrap", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);

        op(16'd5, 16'd7, 2'b00);
        for (int i = 0; i < 3; i++) begin
            Ain = 16'(i * 1111 + 3); Bin = 16'(i * 777 + 9); ALUop = 2'(i + 1);
            @(posedge clk); #1;
            expect_all("hold", 16'd12, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Ain = 16'($urandom); Bin = 16'($urandom); ALUop = 2'($urandom);
            @(posedge clk); #1;
            chk("stream_valid", 16'(valid), 16'h1);
        end
        #2 rst_n = 1'b0;
        #1 expect_all("async_rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        expect_all("rst_ignores_load", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        Ain = 16'd1; Bin = 16'd2; ALUop = 2'b00;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        expect_all("resume", 16'd3, 1'b0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            load = ($urandom_range(0, 9) < 7);
            ALUop = 2'($urandom);
            case ($urandom_range(0, 3))
                0: Ain = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
                1: Ain = 16'($urandom_range(0, 3));
                default: Ain = 16'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: Bin = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h8000;
                1: Bin = Ain;
                default: Bin = 16'($urandom);
            endcase
            @(posedge clk); #1;
        end
        load = 1'b0;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
